// File: rtl/config_arbiter.sv
// config_arbiter: round-robin arbiter sharing one configuration write port between three
// requesters. Each accepted request becomes a single-cycle config_en pulse.
// Optional settle hold-off after writes to the CRC-enable register, built only when the
// macro CFG_ARB_HOLDOFF_EN is defined.
module config_arbiter #(
   parameter logic [1:0]  CRC_EN_REG_ADDR = 2'h3,
   parameter int unsigned HOLDOFF_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req_valid,
   input  logic [5:0] req_addr,
   input  logic [5:0] req_data,
   output logic [2:0] req_ready,
   output logic [1:0] config_addr,
   output logic [1:0] config_data,
   output logic       config_en,
   output logic       busy,
   output logic [1:0] last_gnt
);

`ifdef CFG_ARB_HOLDOFF_EN
   typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

   localparam logic [7:0] HoldLoad = 8'(HOLDOFF_CYCLES);

   logic [7:0] hold_cnt_q;
`else
   typedef enum logic [0:0] {StIdle, StWrite} state_e;

   // Parameters are inert without the hold-off; fold them into a deliberately unused net.
   logic unused_cfg;
   assign unused_cfg = ^{CRC_EN_REG_ADDR, HOLDOFF_CYCLES};
`endif

   state_e     state_q;
   logic [1:0] cand1;
   logic [1:0] cand2;
   logic       any_valid;
   logic [1:0] winner;
   logic [1:0] win_addr;
   logic [1:0] win_data;

   // Round-robin search starting just after the last accepted requester
   always_comb begin
      cand1     = (last_gnt == 2'd2) ? 2'd0 : last_gnt + 2'd1;
      cand2     = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
      any_valid = |req_valid;
      winner    = last_gnt;
      if (req_valid[cand1]) begin
         winner = cand1;
      end else if (req_valid[cand2]) begin
         winner = cand2;
      end
   end

   // Grant is combinational from valid, state and pointer only
   always_comb begin
      req_ready = 3'b000;
      if (rst_n && (state_q == StIdle) && any_valid) begin
         req_ready[winner] = 1'b1;
      end
   end

   // Select the winning requester's address/data for capture
   always_comb begin
      case (winner)
         2'd1:    begin win_addr = req_addr[3:2]; win_data = req_data[3:2]; end
         2'd2:    begin win_addr = req_addr[5:4]; win_data = req_data[5:4]; end
         default: begin win_addr = req_addr[1:0]; win_data = req_data[1:0]; end
      endcase
   end

   // Sequencer FSM with registered write port, busy flag and grant pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         config_addr <= 2'd0;
         config_data <= 2'd0;
         config_en   <= 1'b0;
         busy        <= 1'b0;
         last_gnt    <= 2'd2;
`ifdef CFG_ARB_HOLDOFF_EN
         hold_cnt_q  <= 8'd0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (any_valid) begin
                  config_addr <= win_addr;
                  config_data <= win_data;
                  config_en   <= 1'b1;
                  last_gnt    <= winner;
                  busy        <= 1'b1;
                  state_q     <= StWrite;
               end
            end
            StWrite: begin
               config_en <= 1'b0;
`ifdef CFG_ARB_HOLDOFF_EN
               if ((HOLDOFF_CYCLES != 0) && (config_addr == CRC_EN_REG_ADDR)) begin
                  hold_cnt_q <= HoldLoad;
                  state_q    <= StHold;
               end else begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
`else
               busy    <= 1'b0;
               state_q <= StIdle;
`endif
            end
`ifdef CFG_ARB_HOLDOFF_EN
            StHold: begin
               // Leave when the counter reads 1: exactly HoldLoad cycles spent here
               if (hold_cnt_q != 8'd0) begin
                  hold_cnt_q <= hold_cnt_q - 8'd1;
               end
               if (hold_cnt_q <= 8'd1) begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
            end
`endif
            default: begin
               config_en <= 1'b0;
               busy      <= 1'b0;
               state_q   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_arbiter.sv
// Self-checking bench for config_arbiter. The reference model tracks the earliest cycle a
// new handshake may occur, the round-robin pointer and the last written address/data.
module tb_config_arbiter;

   localparam int unsigned HOLD = 4;
`ifdef CFG_ARB_HOLDOFF_EN
   localparam int unsigned EXTRA = HOLD;
`else
   localparam int unsigned EXTRA = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic [2:0] req_valid;
   logic [5:0] req_addr;
   logic [5:0] req_data;
   logic [2:0] req_ready;
   logic [1:0] config_addr;
   logic [1:0] config_data;
   logic       config_en;
   logic       busy;
   logic [1:0] last_gnt;

   config_arbiter #(
      .CRC_EN_REG_ADDR (2'h3),
      .HOLDOFF_CYCLES  (HOLD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .config_addr (config_addr),
      .config_data (config_data),
      .config_en   (config_en),
      .busy        (busy),
      .last_gnt    (last_gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   int         cyc;
   int         next_ok;
   int         m_ptr;
   logic       m_en;
   logic [1:0] m_addr;
   logic [1:0] m_data;

   int n_vec;
   int n_err;

   // One cycle: drive inputs, check grant, clock, check registered outputs
   task automatic step(input logic [2:0] v, input logic [5:0] a, input logic [5:0] d,
                       input string tag, output int won, output logic [2:0] seen);
      logic [2:0] exp_ready;
      logic [5:0] sh;
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      #1;
      won = -1;
      if (cyc >= next_ok) begin
         for (int k = 1; k <= 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (v[i] && won < 0) won = i;
         end
      end
      exp_ready = 3'b000;
      if (won >= 0) exp_ready[won] = 1'b1;
      seen = req_ready;
      n_vec++;
      if (req_ready !== exp_ready) begin
         n_err++;
         $display("FAIL %s ready cyc=%0d: got %b want %b", tag, cyc, req_ready, exp_ready);
      end
      @(posedge clk);
      #1;
      if (won >= 0) begin
         sh      = a >> (2 * won);
         m_addr  = sh[1:0];
         sh      = d >> (2 * won);
         m_data  = sh[1:0];
         m_en    = 1'b1;
         m_ptr   = won;
         next_ok = cyc + 2 + ((m_addr == 2'h3) ? int'(EXTRA) : 0);
      end else begin
         m_en = 1'b0;
      end
      cyc++;
      n_vec++;
      if (config_en !== m_en) begin
         n_err++;
         $display("FAIL %s config_en cyc=%0d: got %b want %b", tag, cyc, config_en, m_en);
      end
      n_vec++;
      if (config_addr !== m_addr || config_data !== m_data) begin
         n_err++;
         $display("FAIL %s addr/data cyc=%0d: got %0d/%0d want %0d/%0d", tag, cyc,
                  config_addr, config_data, m_addr, m_data);
      end
      n_vec++;
      if (busy !== (cyc < next_ok)) begin
         n_err++;
         $display("FAIL %s busy cyc=%0d: got %b want %b", tag, cyc, busy, (cyc < next_ok));
      end
      n_vec++;
      if (last_gnt !== 2'(m_ptr)) begin
         n_err++;
         $display("FAIL %s last_gnt cyc=%0d: got %0d want %0d", tag, cyc, last_gnt, m_ptr);
      end
   endtask

   // Assert reset (checking its immediate effect), then release aligned to a clock edge
   task automatic do_reset(input string tag);
      rst_n     = 1'b0;
      req_valid = 3'b111;
      #1;
      n_vec++;
      if (req_ready !== 3'b000 || config_en !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s reset ready/en/busy: got %b/%b/%b want 000/0/0", tag, req_ready,
                  config_en, busy);
      end
      n_vec++;
      if (last_gnt !== 2'd2 || config_addr !== 2'd0 || config_data !== 2'd0) begin
         n_err++;
         $display("FAIL %s reset last_gnt/addr/data: got %0d/%0d/%0d want 2/0/0", tag,
                  last_gnt, config_addr, config_data);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 3'b000;
      cyc       = 0;
      next_ok   = 0;
      m_ptr     = 2;
      m_en      = 1'b0;
      m_addr    = 2'd0;
      m_data    = 2'd0;
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_single();
      int w;
      logic [2:0] s;
      do_reset("single");
      step(3'b001, 6'b000001, 6'b000010, "single", w, s);
      n_vec++;
      if (s !== 3'b001 || config_en !== 1'b1 || config_addr !== 2'd1 || config_data !== 2'd2)
      begin
         n_err++;
         $display("FAIL single strobe: got rdy=%b en=%b a=%0d d=%0d want 001/1/1/2", s,
                  config_en, config_addr, config_data);
      end
      step(3'b000, 6'b0, 6'b0, "single", w, s);
      n_vec++;
      if (last_gnt !== 2'd0 || config_en !== 1'b0) begin
         n_err++;
         $display("FAIL single after: got last_gnt=%0d en=%b want 0/0", last_gnt, config_en);
      end
   endtask

   task automatic test_round_robin();
      int w;
      logic [2:0] s;
      int gnt[$];
      int at[$];
      logic [5:0] a;
      logic [5:0] d;
      do_reset("rr");
      for (int c = 0; c < 12; c++) begin
         a = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
         d = 6'($urandom);
         step(3'b111, a, d, "rr", w, s);
         if (s != 3'b000) begin
            gnt.push_back((s == 3'b001) ? 0 : (s == 3'b010) ? 1 : (s == 3'b100) ? 2 : 9);
            at.push_back(c);
         end
      end
      n_vec++;
      if (gnt.size() != 6) begin
         n_err++;
         $display("FAIL rr grant count: got %0d want 6", gnt.size());
      end
      for (int k = 0; k < gnt.size(); k++) begin
         n_vec++;
         if (gnt[k] != k % 3 || at[k] != 2 * k || (k > 0 && gnt[k] == gnt[k-1])) begin
            n_err++;
            $display("FAIL rr grant %0d: got req %0d at %0d want req %0d at %0d", k, gnt[k],
                     at[k], k % 3, 2 * k);
         end
      end
   endtask

   task automatic test_holdoff();
      int w;
      logic [2:0] s;
      int j;
      logic [5:0] a;
      logic [5:0] d;
      a = {2'd0, 2'd3, 2'd0};
      d = {2'd2, 2'd1, 2'd0};
      do_reset("holdoff");
      step(3'b110, a, d, "holdoff", w, s);
      n_vec++;
      if (s !== 3'b010 || config_en !== 1'b1 || config_addr !== 2'd3) begin
         n_err++;
         $display("FAIL holdoff first: got rdy=%b en=%b a=%0d want 010/1/3", s, config_en,
                  config_addr);
      end
      j = 0;
      s = 3'b000;
      while (s[2] !== 1'b1 && j < 20) begin
         j++;
         step(3'b100, a, d, "holdoff", w, s);
      end
      n_vec++;
      if (j != 2 + int'(EXTRA)) begin
         n_err++;
         $display("FAIL holdoff r2 grant delay: got %0d want %0d", j, 2 + EXTRA);
      end
   endtask

   task automatic test_withdraw();
      int w;
      logic [2:0] s;
      int raise;
      logic saw2;
      logic [5:0] a;
      a = {2'd1, 2'd3, 2'd0};
      raise = (EXTRA == 0) ? 1 : int'(EXTRA);
      saw2 = 1'b0;
      do_reset("withdraw");
      step(3'b010, a, 6'b011011, "withdraw", w, s);
      for (int j = 1; j <= raise + 4; j++) begin
         step((j <= raise) ? 3'b100 : 3'b000, a, 6'b011011, "withdraw", w, s);
         if (s[2]) saw2 = 1'b1;
      end
      n_vec++;
      if (saw2 !== 1'b0 || last_gnt !== 2'd1 || config_en !== 1'b0) begin
         n_err++;
         $display("FAIL withdraw: got saw_ready2=%b last_gnt=%0d en=%b want 0/1/0", saw2,
                  last_gnt, config_en);
      end
   endtask

   task automatic test_mid_reset();
      int w;
      logic [2:0] s;
      do_reset("midrst");
      step(3'b001, 6'b000010, 6'b000011, "midrst", w, s);
      do_reset("midrst_async");
      step(3'b110, 6'b011000, 6'b100100, "midrst", w, s);
      n_vec++;
      if (s !== 3'b010 || last_gnt !== 2'd1) begin
         n_err++;
         $display("FAIL midrst regrant: got rdy=%b last_gnt=%0d want 010/1", s, last_gnt);
      end
   endtask

   task automatic test_random();
      int w;
      logic [2:0] s;
      logic [2:0] pend;
      logic [1:0] pa[3];
      logic [1:0] pd[3];
      logic [5:0] a;
      logic [5:0] d;
      do_reset("random");
      pend = 3'b000;
      for (int i = 0; i < 3; i++) begin pa[i] = 2'd0; pd[i] = 2'd0; end
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               pa[i]   = 2'($urandom);
               pd[i]   = 2'($urandom);
            end else if (pend[i] && $urandom_range(0, 15) == 0) begin
               pend[i] = 1'b0;
            end
         end
         a = {pa[2], pa[1], pa[0]};
         d = {pd[2], pd[1], pd[0]};
         step(pend, a, d, "random", w, s);
         if (w >= 0) pend[w] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b1;
      req_valid = 3'b000;
      req_addr  = 6'd0;
      req_data  = 6'd0;
      cyc       = 0;
      next_ok   = 0;
      m_ptr     = 2;
      m_en      = 1'b0;
      m_addr    = 2'd0;
      m_data    = 2'd0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_holdoff();
      test_withdraw();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
